// File: rtl/laser_echo_target.sv
// laser_echo_target: responder end of the L/S laser pulse interface.
// Watches the meter's laser pulse L and returns an echo pulse S after a
// round trip of 2*dist cycles, standing in for optics plus sensor.
// Optional feature macro: LASERECHO_DROP_EN (every DROP_EVERY-th accepted
// pulse runs its full delay but emits no echo).
module laser_echo_target #(
    parameter int W          = 16,
    parameter int ECHO_LEN   = 1,
    parameter int DROP_EVERY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         L,
    input  logic [W-1:0] dist_in,
    input  logic         dist_ld,
    output logic         S,
    output logic         busy,
    output logic         err,
    output logic [7:0]   echo_cnt
);

    localparam int CW = W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_ECHO  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [CW-1:0] ECHO_LAST = CW'(ECHO_LEN - 1);

    // Reject configurations that cannot produce a sensible echo or drop pattern.
    if (ECHO_LEN < 1 || DROP_EVERY < 2) begin : g_bad_cfg
        $error("laser_echo_target: ECHO_LEN must be >= 1 and DROP_EVERY >= 2");
    end

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_dist;
    logic          r_lq;
    logic          r_s;
    logic          r_err;
    logic [7:0]    r_echo_cnt;

    logic          w_rise;
    logic [W-1:0]  w_dist_eff;
    logic [CW-1:0] w_rt;
    logic          w_suppress;

    // A distance loaded in the same idle cycle as the rising edge applies to
    // that very measurement, so the round trip is built from dist_in then.
    assign w_rise     = L & ~r_lq;
    assign w_dist_eff = dist_ld ? dist_in : r_dist;
    assign w_rt       = {w_dist_eff, 1'b0};

`ifdef LASERECHO_DROP_EN
    logic [7:0] r_pulse_cnt;
    logic       r_drop;
    logic       w_drop_next;

    assign w_drop_next = ((32'(r_pulse_cnt) % DROP_EVERY) == (DROP_EVERY - 1));
    assign w_suppress  = r_drop;

    // Count accepted pulses and latch whether the one just accepted is a lost echo.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse_cnt <= 8'd0;
            r_drop      <= 1'b0;
        end else if (r_state == ST_IDLE && w_rise) begin
            r_pulse_cnt <= r_pulse_cnt + 8'd1;
            r_drop      <= w_drop_next;
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    // Main measurement FSM: idle, count the round trip, hold S, wait for L low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dist     <= '0;
            r_lq       <= 1'b0;
            r_s        <= 1'b0;
            r_err      <= 1'b0;
            r_echo_cnt <= 8'd0;
        end else begin
            r_lq <= L;
            if (w_rise && r_state != ST_IDLE) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (dist_ld) begin
                        r_dist <= dist_in;
                    end
                    if (w_rise) begin
                        r_state <= ST_DELAY;
                        r_cnt   <= w_rt;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ECHO;
                        r_s     <= ~w_suppress;
                        r_cnt   <= ECHO_LAST;
                        if (!w_suppress) begin
                            r_echo_cnt <= r_echo_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ECHO: begin
                    if (r_cnt == '0) begin
                        r_s     <= 1'b0;
                        r_state <= L ? ST_HOLD : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!L) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign S        = r_s;
    assign busy     = (r_state != ST_IDLE);
    assign err      = r_err;
    assign echo_cnt = r_echo_cnt;

endmodule

// File: tb/tb_laser_echo_target.sv
// Directed testbench for laser_echo_target (default build: ECHO_LEN=1).
// Inputs change 1 time unit after a rising edge and outputs are sampled
// at the same point, well away from the next active edge.
`timescale 1ns/1ps
module tb_laser_echo_target;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         L;
    logic [W-1:0] dist_in;
    logic         dist_ld;
    logic         S;
    logic         busy;
    logic         err;
    logic [7:0]   echo_cnt;

    int nChecks = 0;
    int nFail   = 0;

    laser_echo_target #(.W(W), .ECHO_LEN(1), .DROP_EVERY(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .L        (L),
        .dist_in  (dist_in),
        .dist_ld  (dist_ld),
        .S        (S),
        .busy     (busy),
        .err      (err),
        .echo_cnt (echo_cnt)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until S is seen high or the budget runs out; lat = edges waited.
    task automatic waitEcho(input int limit, output int lat);
        lat = 0;
        while (S !== 1'b1 && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic loadDist(input logic [W-1:0] d);
        dist_in = d;
        dist_ld = 1'b1;
        tick();
        dist_ld = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; L = 1'b0; dist_in = '0; dist_ld = 1'b0;
        tick(); tick();
        nChecks++;
        if ({S, busy, err, echo_cnt} !== 11'd0) begin
            nFail++;
            $display("[TB] FAIL reset_state: got S=%b busy=%b err=%b echo_cnt=%0d expected all zero",
                     S, busy, err, echo_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_echo();
        int lat;
        loadDist(16'd5);
        L = 1'b1;
        tick();
        L = 1'b0;
        nChecks++;
        if (busy !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL basic_busy_start: got %b expected 1", busy);
        end
        waitEcho(100, lat);
        nChecks++;
        if (lat != 11) begin
            nFail++;
            $display("[TB] FAIL basic_latency: got %0d expected 11", lat);
        end
        tick();
        nChecks++;
        if (S !== 1'b0 || busy !== 1'b0 || echo_cnt !== 8'd1) begin
            nFail++;
            $display("[TB] FAIL basic_after: got S=%b busy=%b echo_cnt=%0d expected S=0 busy=0 echo_cnt=1",
                     S, busy, echo_cnt);
        end
    endtask

    task automatic test_zero_dist();
        dist_in = '0; dist_ld = 1'b1; L = 1'b1;
        tick();
        dist_ld = 1'b0; L = 1'b0;
        nChecks++;
        if (S !== 1'b0 || busy !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL zero_edge_t: got S=%b busy=%b expected S=0 busy=1", S, busy);
        end
        tick();
        nChecks++;
        if (S !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL zero_latency: got S=%b expected 1", S);
        end
        tick();
        nChecks++;
        if (S !== 1'b0 || busy !== 1'b0 || echo_cnt !== 8'd2) begin
            nFail++;
            $display("[TB] FAIL zero_len: got S=%b busy=%b echo_cnt=%0d expected S=0 busy=0 echo_cnt=2",
                     S, busy, echo_cnt);
        end
    endtask

    task automatic test_held_pulse();
        int lat;
        int extraS;
        int idleSeen;
        loadDist(16'd2);
        L = 1'b1;
        tick();
        waitEcho(50, lat);
        nChecks++;
        if (lat != 5) begin
            nFail++;
            $display("[TB] FAIL held_latency: got %0d expected 5", lat);
        end
        extraS = 0;
        idleSeen = 0;
        for (int i = lat + 1; i < 30; i++) begin
            tick();
            if (S === 1'b1) extraS++;
            if (busy !== 1'b1) idleSeen++;
        end
        nChecks++;
        if (extraS != 0 || idleSeen != 0) begin
            nFail++;
            $display("[TB] FAIL held_single: got extraS=%0d idleCycles=%0d expected 0 and 0", extraS, idleSeen);
        end
        L = 1'b0;
        tick();
        nChecks++;
        if (busy !== 1'b0 || echo_cnt !== 8'd3 || err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL held_release: got busy=%b echo_cnt=%0d err=%b expected 0, 3, 0",
                     busy, echo_cnt, err);
        end
    endtask

    task automatic test_busy_pulse();
        int lat;
        loadDist(16'd20);
        L = 1'b1;
        tick();
        L = 1'b0;
        repeat (9) tick();
        L = 1'b1; dist_in = 16'd3; dist_ld = 1'b1;
        tick();
        L = 1'b0; dist_ld = 1'b0;
        nChecks++;
        if (err !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL busy_err_set: got %b expected 1", err);
        end
        waitEcho(100, lat);
        nChecks++;
        if (lat + 10 != 41) begin
            nFail++;
            $display("[TB] FAIL busy_latency: got %0d expected 41", lat + 10);
        end
        tick();
        L = 1'b1;
        tick();
        L = 1'b0;
        waitEcho(100, lat);
        nChecks++;
        if (lat != 41) begin
            nFail++;
            $display("[TB] FAIL busy_ld_ignored: got latency %0d expected 41", lat);
        end
        tick();
        nChecks++;
        if (err !== 1'b1 || echo_cnt !== 8'd5) begin
            nFail++;
            $display("[TB] FAIL busy_sticky: got err=%b echo_cnt=%0d expected err=1 echo_cnt=5", err, echo_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int sHigh;
        loadDist(16'd50);
        L = 1'b1;
        tick();
        L = 1'b0;
        repeat (29) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nChecks++;
        if (S !== 1'b0 || busy !== 1'b0 || echo_cnt !== 8'd0 || err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL midreset_clear: got S=%b busy=%b echo_cnt=%0d err=%b expected all zero",
                     S, busy, echo_cnt, err);
        end
        sHigh = 0;
        repeat (100) begin
            tick();
            if (S === 1'b1) sHigh++;
        end
        nChecks++;
        if (sHigh != 0) begin
            nFail++;
            $display("[TB] FAIL midreset_abandon: got %0d S cycles expected 0", sHigh);
        end
        loadDist(16'd4);
        L = 1'b1;
        tick();
        L = 1'b0;
        waitEcho(50, lat);
        tick();
        nChecks++;
        if (lat != 9 || echo_cnt !== 8'd1) begin
            nFail++;
            $display("[TB] FAIL midreset_recover: got latency=%0d echo_cnt=%0d expected 9 and 1", lat, echo_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        loadDist(16'd1);
        L = 1'b1;
        tick();
        L = 1'b0;
        waitEcho(20, lat);
        tick();
        L = 1'b1;
        tick();
        L = 1'b0;
        waitEcho(20, lat);
        tick();
        nChecks++;
        if (lat != 3 || echo_cnt !== 8'd3 || err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL b2b: got latency=%0d echo_cnt=%0d err=%b expected 3, 3, 0", lat, echo_cnt, err);
        end
    endtask

    task automatic test_reset_release_high();
        int lat;
        reset = 1'b1; L = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        nChecks++;
        if (busy !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL release_high_trigger: got busy=%b expected 1", busy);
        end
        waitEcho(20, lat);
        tick();
        tick();
        nChecks++;
        if (lat != 1 || busy !== 1'b1 || echo_cnt !== 8'd1) begin
            nFail++;
            $display("[TB] FAIL release_high_hold: got latency=%0d busy=%b echo_cnt=%0d expected 1, 1, 1",
                     lat, busy, echo_cnt);
        end
        L = 1'b0;
        tick();
    endtask

`ifdef LASERECHO_DROP_EN
    task automatic test_drop();
        int sHigh;
        reset = 1'b1; L = 1'b0;
        tick();
        reset = 1'b0;
        loadDist(16'd3);
        for (int p = 1; p <= 8; p++) begin
            L = 1'b1;
            tick();
            L = 1'b0;
            sHigh = 0;
            repeat (12) begin
                tick();
                if (S === 1'b1) sHigh++;
            end
            nChecks++;
            if (sHigh != ((p % 4 == 0) ? 0 : 1)) begin
                nFail++;
                $display("[TB] FAIL drop_pulse%0d: got %0d S cycles expected %0d", p, sHigh,
                         (p % 4 == 0) ? 0 : 1);
            end
        end
        nChecks++;
        if (echo_cnt !== 8'd6) begin
            nFail++;
            $display("[TB] FAIL drop_count: got %0d expected 6", echo_cnt);
        end
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_basic_echo();
        test_zero_dist();
        test_held_pulse();
        test_busy_pulse();
        test_mid_reset();
        test_back_to_back();
        test_reset_release_high();
`ifdef LASERECHO_DROP_EN
        test_drop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
